// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the pipelined multiplier.
//   - mult_mode_e   : operand signedness selection (11 is reserved, acts as 00)
//   - MULT_LAT_MIN/MAX : legal LATENCY range, checked at elaboration by the top
//   - mode_signs()  : per-operand signedness for a given mode
//   - mode_is_signed(): true when the product is interpreted as two's complement
package mult_pkg;

  typedef enum logic [1:0] {
    MULT_MODE_UU   = 2'b00,
    MULT_MODE_SS   = 2'b01,
    MULT_MODE_SU   = 2'b10,
    MULT_MODE_RSVD = 2'b11
  } mult_mode_e;

  localparam int unsigned MULT_LAT_MIN = 2;
  localparam int unsigned MULT_LAT_MAX = 8;

  // Returns {a_signed, b_signed}.
  function automatic logic [1:0] mode_signs(input mult_mode_e mode);
    logic [1:0] s;
    case (mode)
      MULT_MODE_SS: s = 2'b11;
      MULT_MODE_SU: s = 2'b10;
      default:      s = 2'b00;
    endcase
    return s;
  endfunction

  function automatic logic mode_is_signed(input mult_mode_e mode);
    return |mode_signs(mode);
  endfunction

endpackage

// File: rtl/mult_pipelined_multi_valid_line.sv
// mult_valid_line: DEPTH-deep shift register of {valid, tag} entries that
// tracks in-flight multiplies alongside the datapath.
//   clk, reset_n : clock, synchronous active-low reset (clears every entry)
//   flush_i      : clears all in-flight valid bits; din_i still enters stage 0
//   din_i        : {valid, tag} presented at issue
//   done_o       : valid bit of the last stage
//   pre_valid_o  : valid bit of the stage before last (output-load enable)
//   tag_o        : tag of the last stage, held while no valid entry arrives
//   busy_o       : OR of every valid bit
module mult_valid_line
  import mult_pkg::*;
#(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned W     = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic         done_o,
  output logic         pre_valid_o,
  output logic [W-2:0] tag_o,
  output logic         busy_o
);

  logic [W-1:0]     line_q [DEPTH];
  logic [W-1:0]     line_d [DEPTH];
  logic [DEPTH-1:0] valid;

  // A stage only takes a new tag when a valid entry moves into it; otherwise
  // it keeps its old tag with the valid bit cleared. This makes the last
  // stage double as the held tag_out register.
  always_comb begin
    line_d = line_q;
    valid  = '0;

    if (din_i[W-1]) begin
      line_d[0] = din_i;
    end else begin
      line_d[0] = {1'b0, line_q[0][W-2:0]};
    end

    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (line_q[i-1][W-1] && !flush_i) begin
        line_d[i] = line_q[i-1];
      end else begin
        line_d[i] = {1'b0, line_q[i][W-2:0]};
      end
    end

    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid[i] = line_q[i][W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      line_q <= line_d;
    end
  end

  assign done_o      = valid[DEPTH-1];
  assign pre_valid_o = valid[DEPTH-2];
  assign tag_o       = line_q[DEPTH-1][W-2:0];
  assign busy_o      = |valid;

endmodule

// File: rtl/mult_pipelined_multi.sv
// mult_pipelined_multi: fully pipelined WIDTH x WIDTH multiplier, one issue
// per cycle, result LATENCY cycles after issue, matched by caller tag.
//   clk, reset_n : clock, synchronous active-low reset
//   start        : issue an operation this cycle (a, b, mode, tag_in sampled)
//   mode         : 00 u*u, 01 s*s, 10 s(a)*u(b), 11 same as 00
//   a, b         : operands
//   tag_in       : caller tag carried with the operation
//   flush        : cancel every in-flight operation (same-cycle start kept)
//   y            : 2*WIDTH product, held between done pulses
//   done         : one-cycle completion pulse
//   tag_out      : tag of the completing operation, held between pulses
//   busy         : any operation in flight
//   ovf          : product does not fit in WIDTH bits; only implemented when
//                  MULT_OVERFLOW_FLAG_EN is defined, otherwise tied to 0
// Pipeline: capture regs -> multiply reg (MREG) -> LATENCY-2 regs (last = y).
module mult_pipelined_multi
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 5,
  parameter int unsigned TAG_W   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [TAG_W-1:0]   tag_in,
  input  logic               flush,
  output logic [2*WIDTH-1:0] y,
  output logic               done,
  output logic [TAG_W-1:0]   tag_out,
  output logic               busy,
  output logic               ovf
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned NPROD = LATENCY - 1;

  if (LATENCY < MULT_LAT_MIN || LATENCY > MULT_LAT_MAX) begin : g_bad_latency
    $error("mult_pipelined_multi: LATENCY %0d outside legal range", LATENCY);
  end

  // ---------------------------------------------------------------------------
  // Valid / tag tracking
  // ---------------------------------------------------------------------------
  logic pre_valid;
  logic load_y;

  mult_valid_line #(
    .DEPTH (LATENCY),
    .W     (TAG_W + 1)
  ) u_valid_line (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (flush),
    .din_i       ({start, tag_in}),
    .done_o      (done),
    .pre_valid_o (pre_valid),
    .tag_o       (tag_out),
    .busy_o      (busy)
  );

  // The output stage loads only for an operation that survives this edge, so
  // a flushed operation never disturbs the held y/ovf.
  assign load_y = pre_valid && !flush;

  // ---------------------------------------------------------------------------
  // Capture stage
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  mult_mode_e       mode_q, mode_d;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    mode_d = mode_q;
    if (start) begin
      a_d    = a;
      b_d    = b;
      mode_d = mult_mode_e'(mode);
    end
  end

  // ---------------------------------------------------------------------------
  // Multiply
  // ---------------------------------------------------------------------------
  logic [1:0]    signs;
  logic [WIDTH:0] a_ext, b_ext;
  logic [PW-1:0] a_wide, b_wide;
  logic [PW-1:0] mult_res;

  // Operands are widened to WIDTH+1 bits per their signedness, then
  // sign-extended to PW bits; an unsigned PW x PW multiply truncated to PW
  // bits equals the low PW bits of the signed (WIDTH+1)-bit product.
  always_comb begin
    signs    = mode_signs(mode_q);
    a_ext    = {signs[1] & a_q[WIDTH-1], a_q};
    b_ext    = {signs[0] & b_q[WIDTH-1], b_q};
    a_wide   = {{(WIDTH-1){a_ext[WIDTH]}}, a_ext};
    b_wide   = {{(WIDTH-1){b_ext[WIDTH]}}, b_ext};
    mult_res = a_wide * b_wide;
  end

  // ---------------------------------------------------------------------------
  // Product pipe: index 0 is the multiply register, NPROD-1 is y
  // ---------------------------------------------------------------------------
  logic [PW-1:0] prod_in [NPROD];
  logic [PW-1:0] prod_d  [NPROD];
  logic [PW-1:0] prod_q  [NPROD];

  always_comb begin
    prod_in[0] = mult_res;
    for (int unsigned i = 1; i < NPROD; i++) begin
      prod_in[i] = prod_q[i-1];
    end

    prod_d = prod_in;
    if (!load_y) begin
      prod_d[NPROD-1] = prod_q[NPROD-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= MULT_MODE_UU;
      for (int unsigned i = 0; i < NPROD; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      mode_q <= mode_d;
      prod_q <= prod_d;
    end
  end

  assign y = prod_q[NPROD-1];

  // ---------------------------------------------------------------------------
  // Overflow flag
  // ---------------------------------------------------------------------------
`ifdef MULT_OVERFLOW_FLAG_EN
  logic [WIDTH-1:0] res_hi;
  logic             res_lo_msb;
  logic             ovf_in [NPROD];
  logic             ovf_d  [NPROD];
  logic             ovf_q  [NPROD];

  // Flag is derived at the multiply stage, where mode_q still belongs to the
  // operation, and then travels alongside its product.
  always_comb begin
    res_hi     = mult_res[PW-1:WIDTH];
    res_lo_msb = mult_res[WIDTH-1];
    if (mode_is_signed(mode_q)) begin
      ovf_in[0] = (res_hi != {WIDTH{res_lo_msb}});
    end else begin
      ovf_in[0] = (res_hi != '0);
    end
    for (int unsigned i = 1; i < NPROD; i++) begin
      ovf_in[i] = ovf_q[i-1];
    end

    ovf_d = ovf_in;
    if (!load_y) begin
      ovf_d[NPROD-1] = ovf_q[NPROD-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NPROD; i++) begin
        ovf_q[i] <= 1'b0;
      end
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q[NPROD-1];
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mult_pipelined_multi.sv
// Directed testbench for mult_pipelined_multi (WIDTH=32, LATENCY=5, TAG_W=4).
module tb_mult_pipelined_multi;

`ifdef MULT_OVERFLOW_FLAG_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  tag_in;
  logic        flush;
  logic [63:0] y;
  logic        done;
  logic [3:0]  tag_out;
  logic        busy;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  mult_pipelined_multi #(
    .WIDTH   (32),
    .LATENCY (5),
    .TAG_W   (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .mode    (mode),
    .a       (a),
    .b       (b),
    .tag_in  (tag_in),
    .flush   (flush),
    .y       (y),
    .done    (done),
    .tag_out (tag_out),
    .busy    (busy),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait (bounded) for done, check latency and results.
  task automatic run_op(input string name, input logic [1:0] m, input logic [31:0] av,
                        input logic [31:0] bv, input logic [3:0] t,
                        input logic [63:0] ey, input logic eovf);
    int n;
    mode = m; a = av; b = bv; tag_in = t; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_lat"}, 64'(n), 64'd5);
    chk({name, "_y"}, y, ey);
    chk({name, "_tag"}, 64'(tag_out), 64'(t));
    chk({name, "_ovf"}, 64'(ovf), 64'(eovf));
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; flush = 1'b0;
    mode = 2'b00; a = '0; b = '0; tag_in = '0;
    tick();
    tick();
    chk("rst_y", y, 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tag", 64'(tag_out), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    reset_n = 1'b1;
    tick();

    // Max unsigned operands: exact latency and busy window
    mode = 2'b00; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; tag_in = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk("uu_done", 64'(done), 64'(c == 5));
      chk("uu_busy", 64'(busy), 64'(c <= 5));
      if (c == 5) begin
        chk("uu_y", y, 64'hFFFF_FFFE_0000_0001);
        chk("uu_tag", 64'(tag_out), 64'd3);
        chk("uu_ovf", 64'(ovf), 64'(OVF_ON));
      end
      tick();
    end

    // Sign modes with -2 * 3
    run_op("ss",   2'b01, 32'hFFFF_FFFE, 32'd3, 4'd1, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
    run_op("su",   2'b10, 32'hFFFF_FFFE, 32'd3, 4'd2, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
    run_op("uu2",  2'b00, 32'hFFFF_FFFE, 32'd3, 4'd4, 64'h0000_0002_FFFF_FFFA, OVF_ON);
    run_op("rsvd", 2'b11, 32'hFFFF_FFFE, 32'd3, 4'd5, 64'h0000_0002_FFFF_FFFA, OVF_ON);
    // Overflow boundary in signed mode
    run_op("ovf1", 2'b01, 32'h7FFF_FFFF, 32'd2, 4'd6, 64'h0000_0000_FFFF_FFFE, OVF_ON);
    run_op("ovf0", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 64'd1, 1'b0);

    // Back-to-back issue: tags 0..3, a=i+1, b=10
    for (int c = 0; c < 10; c++) begin
      chk("tp_done", 64'(done), 64'(c >= 5 && c <= 8));
      if (done) begin
        chk("tp_y", y, 64'((c - 4) * 10));
        chk("tp_tag", 64'(tag_out), 64'(c - 5));
      end
      start = (c < 4);
      mode = 2'b00; a = 32'(c + 1); b = 32'd10; tag_in = 4'(c);
      tick();
    end
    start = 1'b0;

    // Flush: tags 5,6 cancelled, tag 7 issued with flush completes
    for (int c = 0; c < 10; c++) begin
      chk("fl_done", 64'(done), 64'(c == 7));
      chk("fl_y", y, (c < 7) ? 64'd40 : 64'd204);
      if (c == 7) chk("fl_tag", 64'(tag_out), 64'd7);
      if (c == 8) chk("fl_busy", 64'(busy), 64'd0);
      start = (c <= 2);
      flush = (c == 2);
      mode = 2'b00; a = 32'(c + 100); b = 32'd2; tag_in = 4'(c + 5);
      tick();
    end
    start = 1'b0;
    flush = 1'b0;

    // Reset mid-operation: nothing completes
    for (int c = 0; c < 9; c++) begin
      chk("rm_done", 64'(done), 64'd0);
      if (c == 3) begin
        chk("rm_y", y, 64'd0);
        chk("rm_busy", 64'(busy), 64'd0);
        chk("rm_tag", 64'(tag_out), 64'd0);
      end
      start = (c == 0);
      reset_n = (c != 2);
      mode = 2'b00; a = 32'd3; b = 32'd3; tag_in = 4'd9;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
